ovl_no_transition_checker: RTL and testbench
============================================

Name: ovl_no_transition_checker

Overview:
- Synthesizable-style temporal assertion checker.
- Monitors a state-like expression every clock.
- Flags a violation when the expression takes the value `start_state` in one cycle and then `next_state` in the immediately following cycle.
- Instantiated alongside design logic in simulation benches, clocked by the shared free-running bench clock (100 MHz nominal, 10 ns period).

Parameters:
- `width`, 1: bit width of `test_expr`, `start_state` and `next_state`.
- `severity_level`, 1: 0 = fatal (report, then `$finish`); 1 = error (report, continue); 2 = warning; 3 = info.
- `property_type`, 0: 0 = assert (report and fire); 1 = assume (same as assert); 2 = ignore (no reports, `fire[0]` held 0).
- `msg`, "VIOLATION": text appended to every report.
- `coverage_level`, 0: 0 = no coverage; nonzero = enable the `fire[2]` cover event.

Ports:
- `clock`, input, 1: rising-edge sampling clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: 1 = checker active; 0 = hold state, no fires.
- `test_expr`, input, width: expression under check.
- `start_state`, input, width: trigger value.
- `next_state`, input, width: forbidden successor value.
- `fire`, output, 3: [0] assertion violation, [1] X/Z on `test_expr`, [2] cover (`start_state` reached).

Behaviour:
- One clock domain. Reset is asynchronous and active-low: `reset` low immediately clears all state.
- Reset values:
  - `fire` = 3'b000.
  - `armed` = 0.
  - `prev_expr` = 0.
  - All state is held cleared while `reset` is low.
- `armed` flag, updated at each rising edge with `reset` high and `enable` = 1:
  - `armed` <= (`test_expr` == `start_state`).
  - `start_state` is compared in the same cycle it is sampled; no pipelining of `start_state` or `next_state`.
- Violation:
  - Condition: at a rising edge, `armed` == 1 and `test_expr` == `next_state` (all bits equal).
  - Response: `fire[0]` <= 1 for exactly one cycle (registered, visible after that edge). Otherwise `fire[0]` <= 0.
- Back-to-back patterns:
  - Sequence S,N,S,N produces two separate one-cycle `fire[0]` pulses.
  - When `start_state` == `next_state`: staying at that value for two consecutive samples fires.
  - S,S,N fires on the N edge only. The S,S step itself fires only in the equal-states case.
- Reporting when `fire[0]` is set, unless `property_type` = 2:
  - Display `OVL_ERROR : OVL_NO_TRANSITION : <msg> : time <t> : <hierarchical name>`. Prefix is FATAL/ERROR/WARNING/INFO per `severity_level`.
  - `severity_level` 0: call `$finish` after the message.
- X check:
  - At an enabled edge with `reset` high, if any bit of `test_expr` is X/Z: `fire[1]` <= 1 for one cycle, report `test_expr contains X or Z`, and clear `armed`.
  - X/Z compares are never treated as a match.
- Cover: with `coverage_level` != 0, `fire[2]` pulses one cycle each time `armed` goes 0->1.
- `enable` = 0:
  - `armed` and `prev_expr` hold their values.
  - `fire` <= 0.
  - On re-enable, evaluation resumes from the held `armed`.
- Reset mid-sequence: `armed` clears, so S, reset pulse, N does not fire.
- Inputs may be expressions, e.g. a 1-bit comparison result.
- Size target ~150-250 lines including reporting and X logic.

Test Plan:
- Reset/idle: `reset`=0 for 5 clocks with `test_expr`=0, `start_state`=1, `next_state`=0 -> `fire` stays 000 throughout; no messages.
- Legal hold: release reset, `test_expr` 0 for 5 clocks, then 1 held for 15 clocks (`start_state`=1, `next_state`=0) -> `fire[0]` never asserts. Three parallel instances (including `test_expr` = (popcount(8'h00) <= 1), i.e. constant 1) all stay silent.
- Violation: `start_state`=1, `next_state`=0, drive `test_expr` 1 then 0 on consecutive edges -> `fire[0]`=1 for exactly one cycle after the 0 edge; one ERROR message.
- Repeat/reset interplay: drive 1,0,1,0 -> two `fire[0]` pulses. Drive 1, assert `reset` low asynchronously, release, then 0 -> no fire.
- Enable gating: `enable`=0 during a 1->0 transition -> no fire; re-enable with `test_expr` held 0 -> no fire.
- X and cover: `test_expr`=X for one edge -> `fire[1]` pulses, `fire[0]`=0. With `coverage_level`=1, `test_expr` 0->1 -> `fire[2]` one-cycle pulse.

Source files
------------

// File: rtl/ovl_no_transition_checker_if.sv
// Signal bundle for ovl_no_transition_checker.
//   enable      : 1 = checker active, 0 = hold state and suppress fires
//   test_expr   : expression under check
//   start_state : trigger value
//   next_state  : forbidden successor of start_state
//   fire        : [0] violation, [1] X/Z on test_expr, [2] cover (start_state reached)
// The master modport is the stimulus side; the slave modport is the checker side.
interface ovl_no_transition_checker_if #(
    parameter int unsigned width = 1
) ();

    logic             enable;
    logic [width-1:0] test_expr;
    logic [width-1:0] start_state;
    logic [width-1:0] next_state;
    logic [2:0]       fire;

    modport master (
        output enable,
        output test_expr,
        output start_state,
        output next_state,
        input  fire
    );

    modport slave (
        input  enable,
        input  test_expr,
        input  start_state,
        input  next_state,
        output fire
    );

endinterface

// File: rtl/ovl_no_transition_checker.sv
// Temporal checker: flags test_expr taking start_state in one sampled cycle and
// next_state in the immediately following sampled cycle.
//   clk   : rising-edge sampling clock
//   rst_n : asynchronous active-low reset, clears all state
//   chk   : slave side of ovl_no_transition_checker_if (enable, test_expr,
//           start_state, next_state in; fire out)
// fire bits are registered one-cycle pulses visible after the sampling edge.
module ovl_no_transition_checker #(
    parameter int unsigned width          = 1,
    parameter int unsigned severity_level = 1,
    parameter int unsigned property_type  = 0,
    parameter string       msg            = "VIOLATION",
    parameter int unsigned coverage_level = 0
) (
    input logic                        clk,
    input logic                        rst_n,
    ovl_no_transition_checker_if.slave chk
);

    logic             armed_q, armed_d;
    logic [width-1:0] prev_expr_q, prev_expr_d;
    logic [2:0]       fire_q, fire_d;

    logic expr_unknown;
    logic start_match;
    logic next_match;
    logic violation;

    // Any unknown bit on either side of a compare means "no match".
    always_comb begin
        expr_unknown = $isunknown(chk.test_expr);
        start_match  = !expr_unknown && !$isunknown(chk.start_state) &&
                       (chk.test_expr == chk.start_state);
        next_match   = !expr_unknown && !$isunknown(chk.next_state) &&
                       (chk.test_expr == chk.next_state);
        violation    = chk.enable && armed_q && next_match;
    end

    always_comb begin
        armed_d     = armed_q;
        prev_expr_d = prev_expr_q;
        fire_d      = 3'b000;
        if (chk.enable) begin
            prev_expr_d = chk.test_expr;
            // start_match is already false on X/Z, which also disarms.
            armed_d     = start_match;
            fire_d[0]   = violation && (property_type != 2);
            fire_d[1]   = expr_unknown;
            fire_d[2]   = (coverage_level != 0) && start_match && !armed_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            prev_expr_q <= '0;
            fire_q      <= 3'b000;
        end else begin
            armed_q     <= armed_d;
            prev_expr_q <= prev_expr_d;
            fire_q      <= fire_d;
        end
    end

    assign chk.fire = fire_q;

    // Last enabled sample is kept for debug visibility only.
    logic unused_prev_expr;
    assign unused_prev_expr = ^prev_expr_q;

`ifndef SYNTHESIS
    function automatic string sev_prefix(int unsigned lvl);
        case (lvl)
            0:       return "OVL_FATAL";
            1:       return "OVL_ERROR";
            2:       return "OVL_WARNING";
            default: return "OVL_INFO";
        endcase
    endfunction

    // Reports issue on the same edge that registers the corresponding fire bit.
    always_ff @(posedge clk) begin
        if (rst_n && chk.enable && (property_type != 2)) begin
            if (expr_unknown) begin
                $display("%s : OVL_NO_TRANSITION : test_expr contains X or Z : time %0t : %m",
                         sev_prefix(severity_level), $time);
            end else if (violation) begin
                $display("%s : OVL_NO_TRANSITION : %s : time %0t : %m",
                         sev_prefix(severity_level), msg, $time);
                if (severity_level == 0) begin
                    $finish;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ovl_no_transition_checker.sv
module tb_ovl_no_transition_checker;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // A: 1-bit, start=1 next=0, cover on.
    ovl_no_transition_checker_if #(.width(1)) a_if ();
    // B: 4-bit, cover off, start/next driven per sequence.
    ovl_no_transition_checker_if #(.width(4)) b_if ();
    // C: expression input, constantly 1.
    ovl_no_transition_checker_if #(.width(1)) c_if ();

    logic [7:0] zero_byte;
    assign zero_byte        = 8'h00;
    assign c_if.enable      = 1'b1;
    assign c_if.start_state = 1'b1;
    assign c_if.next_state  = 1'b0;
    assign c_if.test_expr   = ($countones(zero_byte) <= 1);

    ovl_no_transition_checker #(
        .width(1), .severity_level(3), .property_type(0), .msg("VIOLATION"), .coverage_level(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .chk(a_if)
    );

    ovl_no_transition_checker #(
        .width(4), .severity_level(3), .property_type(0), .msg("VIOLATION"), .coverage_level(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .chk(b_if)
    );

    ovl_no_transition_checker #(
        .width(1), .severity_level(3), .property_type(0), .msg("VIOLATION"), .coverage_level(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .chk(c_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic       expr;
        logic [2:0] exp_fire;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic expr, input logic [2:0] exp_fire);
        vec_t v;
        v.en       = en;
        v.expr     = expr;
        v.exp_fire = exp_fire;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: fire=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic probe;
        bit   four_state;

        checks = 0;
        errors = 0;
        probe  = 1'bx;
        four_state = (probe === 1'bx);

        // Sequence for A, starting from armed=0 right after reset release.
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 3'b000);
        add(1'b1, 1'b1, 3'b100);                                // arm -> cover
        for (int i = 0; i < 14; i++) add(1'b1, 1'b1, 3'b000);   // legal hold
        add(1'b1, 1'b0, 3'b001);                                // 1->0 violation
        add(1'b1, 1'b0, 3'b000);
        add(1'b1, 1'b1, 3'b100);
        add(1'b1, 1'b0, 3'b001);                                // S,N,S,N pulse 1
        add(1'b1, 1'b1, 3'b100);
        add(1'b1, 1'b0, 3'b001);                                // pulse 2
        add(1'b0, 1'b1, 3'b000);                                // gated 1->0
        add(1'b0, 1'b0, 3'b000);
        add(1'b1, 1'b0, 3'b000);                                // re-enable, armed was 0
        add(1'b1, 1'b1, 3'b100);
        add(1'b0, 1'b1, 3'b000);                                // armed held through gap
        add(1'b0, 1'b0, 3'b000);
        add(1'b1, 1'b0, 3'b001);                                // resumes from held armed
        add(1'b1, 1'b0, 3'b000);

        rst_n            = 1'b0;
        a_if.enable      = 1'b1;
        a_if.test_expr   = 1'b0;
        a_if.start_state = 1'b1;
        a_if.next_state  = 1'b0;
        b_if.enable      = 1'b1;
        b_if.test_expr   = 4'h0;
        b_if.start_state = 4'h5;
        b_if.next_state  = 4'h5;

        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("reset_a_%0d", i), a_if.fire, 3'b000);
            check($sformatf("reset_b_%0d", i), b_if.fire, 3'b000);
            check($sformatf("reset_c_%0d", i), c_if.fire, 3'b000);
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            a_if.enable    = vecs[i].en;
            a_if.test_expr = vecs[i].expr;
            tick();
            check($sformatf("row%0d_a", i), a_if.fire, vecs[i].exp_fire);
            check($sformatf("row%0d_c", i), c_if.fire, 3'b000);
        end

        // Async reset between S and N.
        a_if.enable    = 1'b1;
        a_if.test_expr = 1'b1;
        tick();
        check("rst_mid_arm", a_if.fire, 3'b100);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_async_clear", a_if.fire, 3'b000);
        #2 rst_n = 1'b1;
        a_if.test_expr = 1'b0;
        tick();
        check("rst_mid_no_fire", a_if.fire, 3'b000);
        a_if.test_expr = 1'b1;
        tick();
        check("rst_mid_rearm", a_if.fire, 3'b100);

        // B, start == next: staying on the value fires every cycle.
        b_if.test_expr = 4'h3;
        tick();
        check("b_eq_idle", b_if.fire, 3'b000);
        b_if.test_expr = 4'h5;
        tick();
        check("b_eq_first_no_cover", b_if.fire, 3'b000);
        tick();
        check("b_eq_second_fires", b_if.fire, 3'b001);
        tick();
        check("b_eq_third_fires", b_if.fire, 3'b001);
        b_if.test_expr = 4'h9;
        tick();
        check("b_eq_leave", b_if.fire, 3'b000);

        // B, start != next: S,S,N fires only on N.
        b_if.next_state = 4'hA;
        b_if.test_expr  = 4'h5;
        tick();
        check("b_ssn_s1", b_if.fire, 3'b000);
        tick();
        check("b_ssn_s2", b_if.fire, 3'b000);
        b_if.test_expr = 4'hA;
        tick();
        check("b_ssn_n", b_if.fire, 3'b001);
        b_if.test_expr = 4'hA;
        tick();
        check("b_ssn_after", b_if.fire, 3'b000);

        // X on test_expr: A is armed here; X must flag and disarm without a violation.
        if (four_state) begin
            a_if.test_expr = 1'bx;
            tick();
            check("x_flag", a_if.fire, 3'b010);
            a_if.test_expr = 1'b0;
            tick();
            check("x_disarms", a_if.fire, 3'b000);
        end else begin
            $display("note: two-state simulator, X/Z sequence not applied");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
